// File: rtl/fp_seq_multiplier.sv
// rtl/fp_seq_multiplier.sv - sequential shift-add IEEE-754 multiplier with RNE rounding and special values
module fp_seq_multiplier #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   invalid
);
    localparam int W    = EXP_W + MAN_W + 1;
    localparam int SW   = MAN_W + 1;
    localparam int P    = 2 * SW;
    localparam int EW   = EXP_W + 2;
    localparam int CW   = $clog2(SW + 1);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, NORM, ROUND} state_t;

    state_t                 state_q, state_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic [W-1:0]           result_q, result_d;
    logic                   ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;
    logic                   sign_q, sign_d;
    logic signed [EW-1:0]   e_q, e_d;
    logic [P-1:0]           acc_q, acc_d, mcand_q, mcand_d;
    logic [SW-1:0]          mplier_q, mplier_d, sig_q, sig_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   guard_q, guard_d, sticky_q, sticky_d;
    logic                   nan_q, nan_d, infzero_q, infzero_d, inf_q, inf_d, zero_q, zero_d;

    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W-1:0]       fa, fb;
    logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [P-1:0]           norm;
    logic [SW:0]            rnd;
    logic                   carry;
    logic [MAN_W-1:0]       frac;
    logic signed [EW-1:0]   e_r;

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        inv_d     = inv_q;
        sign_d    = sign_q;
        e_d       = e_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        sig_d     = sig_q;
        guard_d   = guard_q;
        sticky_d  = sticky_q;
        nan_d     = nan_q;
        infzero_d = infzero_q;
        inf_d     = inf_q;
        zero_d    = zero_q;

        ea     = a[W-2:MAN_W];
        eb     = b[W-2:MAN_W];
        fa     = a[MAN_W-1:0];
        fb     = b[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (&ea) && !(|fa);
        b_inf  = (&eb) && !(|fb);
        a_nan  = (&ea) && (|fa);
        b_nan  = (&eb) && (|fb);

        norm  = acc_q[P-1] ? acc_q : (acc_q << 1);
        rnd   = {1'b0, sig_q} + {{SW{1'b0}}, guard_q & (sticky_q | sig_q[0])};
        carry = rnd[SW];
        frac  = carry ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        e_r   = e_q + EW'(carry);

        unique case (state_q)
            IDLE: begin
                // Operands are latched on the accept edge so they may change right after it.
                if (start) begin
                    state_d   = MUL;
                    busy_d    = 1'b1;
                    ovf_d     = 1'b0;
                    unf_d     = 1'b0;
                    inv_d     = 1'b0;
                    sign_d    = a[W-1] ^ b[W-1];
                    e_d       = {2'b00, ea} + {2'b00, eb} - EW'(BIAS);
                    nan_d     = a_nan | b_nan;
                    infzero_d = (a_inf & b_zero) | (b_inf & a_zero);
                    inf_d     = a_inf | b_inf;
                    zero_d    = a_zero | b_zero;
                    acc_d     = '0;
                    mcand_d   = {{(P-SW){1'b0}}, ~a_zero, fa};
                    mplier_d  = {~b_zero, fb};
                    cnt_d     = '0;
                end
            end
            MUL: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(MAN_W)) state_d = NORM;
            end
            NORM: begin
                sig_d    = norm[P-1 -: SW];
                guard_d  = norm[MAN_W];
                sticky_d = |norm[MAN_W-1:0];
                e_d      = e_q + EW'(acc_q[P-1]);
                state_d  = ROUND;
            end
            ROUND: begin
                if (nan_q) begin
                    result_d = QNAN;
                end else if (infzero_q) begin
                    result_d = QNAN;
                    inv_d    = 1'b1;
                end else if (inf_q) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (zero_q) begin
                    result_d = {sign_q, {(W-1){1'b0}}};
                end else if (!e_r[EW-1] && (e_r >= EMAX_S)) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ovf_d    = 1'b1;
                end else if (e_r[EW-1] || (e_r == '0)) begin
                    result_d = {sign_q, {(W-1){1'b0}}};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, e_r[EXP_W-1:0], frac};
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inv_q     <= 1'b0;
            sign_q    <= 1'b0;
            e_q       <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            sig_q     <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            nan_q     <= 1'b0;
            infzero_q <= 1'b0;
            inf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            inv_q     <= inv_d;
            sign_q    <= sign_d;
            e_q       <= e_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            sig_q     <= sig_d;
            guard_q   <= guard_d;
            sticky_q  <= sticky_d;
            nan_q     <= nan_d;
            infzero_q <= infzero_d;
            inf_q     <= inf_d;
            zero_q    <= zero_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign invalid   = inv_q;
endmodule

// File: tb/tb_fp_seq_multiplier.sv
// tb/tb_fp_seq_multiplier.sv - directed vector bench for binary32 and binary16 fp_seq_multiplier
module tb_fp_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst, start, busy, done, ovf, unf, inv;
    logic [31:0] a, b, result;
    logic        h_start, h_busy, h_done, h_ovf, h_unf, h_inv;
    logic [15:0] h_a, h_b, h_result;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_seq_multiplier #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .overflow(ovf), .underflow(unf), .invalid(inv)
    );

    fp_seq_multiplier #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .start(h_start), .a(h_a), .b(h_b),
        .busy(h_busy), .done(h_done), .result(h_result),
        .overflow(h_ovf), .underflow(h_unf), .invalid(h_inv)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  fl;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input int p1, input int p2,
                         output logic [31:0] r, output logic [2:0] f, output int lat,
                         output int ndone, output logic bok);
        int acc;
        @(negedge clk);
        a = ta; b = tb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom;
        acc = cyc; lat = -1; ndone = 0; bok = busy; r = '0; f = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = (i == p1) || (i == p2);
            if (done) begin
                ndone++;
                bok &= !busy;
                if (lat < 0) begin
                    lat = cyc - acc;
                    r = result;
                    f = {ovf, unf, inv};
                end
            end else if (lat < 0) begin
                bok &= busy;
            end
        end
        start = 1'b0;
    endtask

    task automatic do_h(input logic [15:0] ta, input logic [15:0] tb,
                        output logic [15:0] r, output logic [2:0] f, output int lat);
        int acc;
        @(negedge clk);
        h_a = ta; h_b = tb; h_start = 1'b1;
        @(negedge clk);
        h_start = 1'b0;
        acc = cyc; lat = -1; r = '0; f = '0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (h_done && lat < 0) begin
                lat = cyc - acc;
                r = h_result;
                f = {h_ovf, h_unf, h_inv};
            end
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] hr;
        logic [2:0]  f;
        int          lat, nd, acc, dn;
        int          dcyc[3];
        logic        bok;

        // {a, b, expected product, {overflow, underflow, invalid}}
        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000};
        vecs[1]  = '{32'hC0400000, 32'h3F000000, 32'hBFC00000, 3'b000};
        vecs[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000};
        vecs[3]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001};
        vecs[4]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000};
        vecs[5]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100};
        vecs[6]  = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b010};
        vecs[7]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000};
        vecs[8]  = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000};
        vecs[9]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b000};
        vecs[10] = '{32'h80000000, 32'h40000000, 32'h80000000, 3'b000};
        vecs[11] = '{32'h00000001, 32'h3F800000, 32'h00000000, 3'b000};
        vecs[12] = '{32'h7F800000, 32'hFF800000, 32'hFF800000, 3'b000};
        vecs[13] = '{32'hBF800000, 32'h3F800000, 32'hBF800000, 3'b000};
        vecs[14] = '{32'h00800000, 32'h3F800000, 32'h00800000, 3'b000};
        vecs[15] = '{32'h00800000, 32'h3F000000, 32'h00000000, 3'b010};
        vecs[16] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100};
        vecs[17] = '{32'h00000000, 32'hFF800000, 32'h7FC00000, 3'b001};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        h_start = 1'b0; h_a = '0; h_b = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {busy, done, ovf, unf, inv, result}, '0);
        check("reset_state_h", {h_busy, h_done, h_ovf, h_unf, h_inv, h_result}, '0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            do_op(vecs[i].a, vecs[i].b, 0, 0, r, f, lat, nd, bok);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_flags", i), f, vecs[i].fl);
            check($sformatf("vec%0d_latency", i), lat, 26);
            check($sformatf("vec%0d_done_count", i), nd, 1);
            check($sformatf("vec%0d_busy", i), bok, 1'b1);
        end

        do_op(32'h3FC00000, 32'h40000000, 5, 20, r, f, lat, nd, bok);
        check("ignored_start_done_count", nd, 1);
        check("ignored_start_result", r, 32'h40400000);
        check("ignored_start_latency", lat, 26);

        @(negedge clk);
        a = 32'hC0400000; b = 32'h3F000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_abort_outputs", {busy, done, ovf, unf, inv, result}, '0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("rst_abort_no_done", dn, 0);

        do_op(32'h7F000000, 32'h7F000000, 0, 0, r, f, lat, nd, bok);
        check("after_rst_result", r, 32'h7F800000);
        check("after_rst_flags", f, 3'b100);
        check("after_rst_latency", lat, 26);

        do_h(16'h3E00, 16'h4000, hr, f, lat);
        check("h_result", hr, 16'h4200);
        check("h_flags", f, 3'b000);
        check("h_latency", lat, 13);
        do_h(16'h3E00, 16'h3D55, hr, f, lat);
        check("h_round_carry_result", hr, 16'h4000);
        check("h_round_carry_latency", lat, 13);

        @(negedge clk);
        h_a = 16'h3E00; h_b = 16'h4000; h_start = 1'b1;
        @(negedge clk);
        acc = cyc; dn = 0;
        for (int i = 0; i < 3; i++) dcyc[i] = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (h_done) begin
                if (dn < 3) dcyc[dn] = cyc;
                dn++;
                check($sformatf("b2b_result%0d", dn), h_result, 16'h4200);
            end
        end
        h_start = 1'b0;
        check("b2b_first_latency", dcyc[0] - acc, 13);
        check("b2b_interval1", dcyc[1] - dcyc[0], 14);
        check("b2b_interval2", dcyc[2] - dcyc[1], 14);
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
